// File: rtl/sram_fifo_ctrl_if.sv
// rtl/sram_fifo_ctrl_if.sv - write/read valid-ready stream bundle for sram_fifo_ctrl
interface sram_fifo_ctrl_if #(
  parameter int DATA_W = 64
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - FWFT FIFO over a 1rw1r SRAM macro; optional SRAM_FIFO_BYPASS_EN
module sram_fifo_ctrl #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  sram_fifo_ctrl_if.slave   bus,
  output logic [ADDR_W:0]   count,
  output logic              mem_rw_ce,
  output logic              mem_rw_we,
  output logic [ADDR_W-1:0] mem_rw_addr,
  output logic [DATA_W-1:0] mem_rw_wd,
  output logic              mem_r_ce,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_r_rd
);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   mem_count, mem_count_n;
  logic              inflight;
  logic [1:0]        out_count, out_count_n;
  logic [DATA_W-1:0] buf0, buf1, buf0_n, buf1_n;

  logic              pop, wr_fire, byp_ok, byp_fire, mem_write, rd_issue, cap;
  logic [1:0]        kept, slots;
  logic [DATA_W-1:0] cap_data;

  // Occupancy and handshakes: count covers SRAM words, the pending read and the output buffer
  assign count        = mem_count + {{ADDR_W{1'b0}}, inflight} + {{(ADDR_W-1){1'b0}}, out_count};
  assign bus.rd_valid = (out_count != 2'd0);
  assign bus.rd_data  = buf0;
  assign bus.wr_ready = rst_n & ~flush & (count < DEPTH_C);
  assign pop          = bus.rd_valid & bus.rd_ready;
  assign wr_fire      = bus.wr_valid & bus.wr_ready;
  assign kept         = out_count - {1'b0, pop};
  assign slots        = kept + {1'b0, inflight};

`ifdef SRAM_FIFO_BYPASS_EN
  assign byp_ok = (mem_count == '0) & ~inflight & (kept < 2'd2);
`else
  assign byp_ok = 1'b0;
`endif

  assign byp_fire  = wr_fire & byp_ok;
  assign mem_write = wr_fire & ~byp_ok;
  // A read is issued only when the buffer is guaranteed room for the returning word
  assign rd_issue  = ~flush & (mem_count != '0) & (slots < 2'd2);

  assign mem_rw_ce   = mem_write;
  assign mem_rw_we   = mem_write;
  assign mem_rw_addr = wptr;
  assign mem_rw_wd   = mem_write ? bus.wr_data : '0;
  assign mem_r_ce    = rd_issue;
  assign mem_r_addr  = rptr;

  // Output buffer shift/append and SRAM word count next-state
  always_comb begin
    buf0_n      = buf0;
    buf1_n      = buf1;
    mem_count_n = mem_count;
    cap         = inflight | byp_fire;
    cap_data    = inflight ? mem_r_rd : bus.wr_data;
    if (pop && (out_count == 2'd2)) begin
      buf0_n = buf1;
    end
    if (cap) begin
      if (kept == 2'd0) begin
        buf0_n = cap_data;
      end else begin
        buf1_n = cap_data;
      end
    end
    out_count_n = kept + {1'b0, cap};
    if (mem_write && !rd_issue) begin
      mem_count_n = mem_count + (ADDR_W+1)'(1);
    end else if (!mem_write && rd_issue) begin
      mem_count_n = mem_count - (ADDR_W+1)'(1);
    end
  end

  // State registers; flush clears occupancy and drops any pending return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      mem_count <= '0;
      inflight  <= 1'b0;
      out_count <= 2'd0;
      buf0      <= '0;
      buf1      <= '0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      mem_count <= '0;
      inflight  <= 1'b0;
      out_count <= 2'd0;
    end else begin
      if (mem_write) begin
        wptr <= (wptr == LAST_C) ? '0 : wptr + ADDR_W'(1);
      end
      if (rd_issue) begin
        rptr <= (rptr == LAST_C) ? '0 : rptr + ADDR_W'(1);
      end
      mem_count <= mem_count_n;
      inflight  <= rd_issue;
      out_count <= out_count_n;
      buf0      <= buf0_n;
      buf1      <= buf1_n;
    end
  end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - self-checking bench for sram_fifo_ctrl with SRAM model and queue scoreboard
module tb_sram_fifo_ctrl;
  localparam int DW = 64;
  localparam int AW = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  sram_fifo_ctrl_if #(.DATA_W(DW)) bus();

  logic [AW:0]   count;
  logic          mem_rw_ce, mem_rw_we, mem_r_ce;
  logic [AW-1:0] mem_rw_addr, mem_r_addr;
  logic [DW-1:0] mem_rw_wd;
  logic [DW-1:0] mem_r_rd;

  sram_fifo_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .count(count),
    .mem_rw_ce(mem_rw_ce), .mem_rw_we(mem_rw_we), .mem_rw_addr(mem_rw_addr),
    .mem_rw_wd(mem_rw_wd), .mem_r_ce(mem_r_ce), .mem_r_addr(mem_r_addr),
    .mem_r_rd(mem_r_rd)
  );

  // Macro model: 1-cycle read latency, garbage on the read port when not enabled
  logic [DW-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (mem_rw_ce && mem_rw_we) sram[mem_rw_addr] <= mem_rw_wd;
    if (mem_r_ce) mem_r_rd <= sram[mem_r_addr];
    else mem_r_rd <= {$urandom, $urandom};
  end

  int n_checks = 0;
  int n_fail = 0;
  int n_pops = 0;
  int max_count = 0;
  logic [DW-1:0] q[$];

  typedef struct {
    logic          wv;
    logic [DW-1:0] wd;
    logic          rr;
    logic          exp_rv;
    logic [AW:0]   exp_cnt;
    logic [DW-1:0] exp_rd;
  } vec_t;
  vec_t vt[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic wv, input logic [DW-1:0] wd, input logic rr);
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
  endtask

  // One clock: check against the queue model mid-cycle, then advance to just after the edge
  task automatic cycle();
    @(negedge clk);
    chk("count_vs_model", 64'(count), 64'(q.size()));
    chk("wr_ready_vs_model", 64'(bus.wr_ready), 64'(rst_n && !flush && q.size() < DEPTH));
    chk("rd_valid_when_empty", 64'(bus.rd_valid && q.size() == 0), 64'd0);
    chk("we_without_ce", 64'(mem_rw_we & ~mem_rw_ce), 64'd0);
    if (int'(count) > max_count) max_count = int'(count);
    if (flush || !rst_n) begin
      q.delete();
    end else begin
      if (bus.rd_valid && bus.rd_ready && q.size() > 0) begin
        chk("pop_data", bus.rd_data, q.pop_front());
        n_pops++;
      end
      if (bus.wr_valid && bus.wr_ready) q.push_back(bus.wr_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rv(input string name);
    int k = 0;
    while (!bus.rd_valid && k < 10) begin
      cycle();
      k++;
    end
    chk(name, 64'(bus.rd_valid), 64'd1);
  endtask

  localparam logic [DW-1:0] A = 64'hDEAD_BEEF_0000_0001;
  localparam logic [DW-1:0] B = 64'hDEAD_BEEF_0000_0002;
  localparam logic [DW-1:0] C = 64'hDEAD_BEEF_0000_0003;
  localparam logic [DW-1:0] D = 64'hDEAD_BEEF_0000_0004;

  initial begin
    int p0, k;
    set_in(1'b0, '0, 1'b0);

`ifdef SRAM_FIFO_BYPASS_EN
    vt[0]  = '{1'b1, A,   1'b0, 1'b1, 7'd1, A};
    vt[1]  = '{1'b0, '0,  1'b0, 1'b1, 7'd1, A};
    vt[2]  = '{1'b0, '0,  1'b0, 1'b1, 7'd1, A};
    vt[3]  = '{1'b1, B,   1'b1, 1'b1, 7'd1, B};
    vt[4]  = '{1'b0, '0,  1'b0, 1'b1, 7'd1, B};
    vt[5]  = '{1'b0, '0,  1'b0, 1'b1, 7'd1, B};
`else
    vt[0]  = '{1'b1, A,   1'b0, 1'b0, 7'd1, '0};
    vt[1]  = '{1'b0, '0,  1'b0, 1'b0, 7'd1, '0};
    vt[2]  = '{1'b0, '0,  1'b0, 1'b1, 7'd1, A};
    vt[3]  = '{1'b1, B,   1'b1, 1'b0, 7'd1, A};
    vt[4]  = '{1'b0, '0,  1'b0, 1'b0, 7'd1, A};
    vt[5]  = '{1'b0, '0,  1'b0, 1'b1, 7'd1, B};
`endif
    vt[6]  = '{1'b1, C,   1'b0, 1'b1, 7'd2, B};
    vt[7]  = '{1'b1, D,   1'b0, 1'b1, 7'd3, B};
    vt[8]  = '{1'b0, '0,  1'b1, 1'b1, 7'd2, C};
    vt[9]  = '{1'b0, '0,  1'b1, 1'b1, 7'd1, D};
    vt[10] = '{1'b0, '0,  1'b1, 1'b0, 7'd0, D};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_strobes", 64'({mem_rw_ce, mem_rw_we, mem_r_ce}), 64'd0);
    chk("rst_addrs", 64'({mem_rw_addr, mem_r_addr}), 64'd0);
    chk("rst_wd", mem_rw_wd, 64'd0);
    chk("rst_rd_data", bus.rd_data, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_wr_ready", 64'(bus.wr_ready), 64'd1);

    // Table: latency, pop/write overlap, shift-and-append, empty hold
    for (int i = 0; i < 11; i++) begin
      set_in(vt[i].wv, vt[i].wd, vt[i].rr);
      cycle();
      chk($sformatf("vec%0d_rd_valid", i), 64'(bus.rd_valid), 64'(vt[i].exp_rv));
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].exp_cnt));
      chk($sformatf("vec%0d_rd_data", i), bus.rd_data, vt[i].exp_rd);
    end

    // Fill to full, hold off extra writes, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 64'(i), 1'b0);
      cycle();
    end
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_wr_ready", 64'(bus.wr_ready), 64'd0);
    set_in(1'b1, 64'hBAD, 1'b0);
    repeat (3) cycle();
    chk("full_held_count", 64'(count), 64'(DEPTH));
    set_in(1'b0, '0, 1'b1);
    p0 = n_pops;
    k = 0;
    while ((q.size() > 0 || count != 0) && k < 200) begin
      cycle();
      k++;
    end
    chk("drain_pops", 64'(n_pops - p0), 64'(DEPTH));
    chk("drain_count", 64'(count), 64'd0);

    // Streaming across pointer wrap
    max_count = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == 50) p0 = n_pops;
      set_in(1'b1, 64'(1000 + i), 1'b1);
      cycle();
    end
    chk("stream_rate", 64'(n_pops - p0), 64'd150);
    chk("stream_max_count", 64'(max_count <= 3), 64'd1);
    set_in(1'b0, '0, 1'b1);
    repeat (6) cycle();
    chk("stream_drained", 64'(count), 64'd0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 5000; i++) begin
      set_in(1'($urandom % 2), {$urandom, $urandom}, 1'($urandom % 2));
      cycle();
    end
    set_in(1'b0, '0, 1'b1);
    k = 0;
    while (q.size() > 0 && k < 300) begin
      cycle();
      k++;
    end
    cycle();
    chk("rand_drained_model", 64'(q.size()), 64'd0);
    chk("rand_drained_count", 64'(count), 64'd0);

    // Flush while a read is in flight with five words stored
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 64'(100 + i), 1'b0);
      cycle();
    end
    set_in(1'b0, '0, 1'b0);
    repeat (3) cycle();
    set_in(1'b1, 64'd105, 1'b1);
    #1;
    chk("pre_flush_read_issue", 64'(mem_r_ce), 64'd1);
    cycle();
    chk("pre_flush_count", 64'(count), 64'd5);
    set_in(1'b1, 64'hAA, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_no_strobes", 64'({mem_rw_ce, mem_r_ce}), 64'd0);
    chk("flush_wr_ready", 64'(bus.wr_ready), 64'd0);
    cycle();
    flush = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_rd_valid", 64'(bus.rd_valid), 64'd0);
    set_in(1'b0, '0, 1'b0);
    cycle();
    chk("flush_stale_dropped", 64'({bus.rd_valid, count}), 64'd0);
    set_in(1'b1, 64'h55, 1'b0);
    cycle();
    set_in(1'b0, '0, 1'b0);
    wait_rv("flush_after_rv");
    chk("flush_after_data", bus.rd_data, 64'h55);
    set_in(1'b0, '0, 1'b1);
    cycle();
    set_in(1'b0, '0, 1'b0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 64'(200 + i), 1'b1);
      cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("arst_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_strobes", 64'({mem_rw_ce, mem_rw_we, mem_r_ce}), 64'd0);
    chk("arst_addrs", 64'({mem_rw_addr, mem_r_addr}), 64'd0);
    q.delete();
    set_in(1'b0, '0, 1'b0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("post_arst_empty", 64'({bus.rd_valid, count}), 64'd0);
    set_in(1'b1, 64'h77, 1'b0);
    cycle();
    set_in(1'b0, '0, 1'b0);
    wait_rv("post_arst_rv");
    chk("post_arst_data", bus.rd_data, 64'h77);
    set_in(1'b0, '0, 1'b1);
    cycle();
    chk("post_arst_final_count", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
